pwm_capture: RTL and testbench

PWM decoder and duty-cycle capture block, the receive-side counterpart of the team's 4-bit counter-based PWM generator.
- Samples an asynchronous PWM waveform and measures, in CLK cycles, the high time and the rising-edge-to-rising-edge period of each frame.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a stuck-high or stuck-low line (0%/100% duty) after a timeout.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sync_edge.sv | 36 +++
 rtl/pwm_capture.sv | 96 +++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

  // Default width of the high-time and period counters.
  localparam int PWM_CNT_W = 8;

  // Frame length of the team's 4-bit counter PWM generator, for paired benches.
  localparam int PWM_GEN_PERIOD = 16;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no rise seen since reset or since the last timeout
    HIGH = 2'd1,  // inside the high phase of a frame
    LOW  = 2'd2   // inside the low phase of a frame
  } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous PWM line, plus a delay flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module pwm_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize pwm_in (s1, s2) and keep one cycle of history (s3).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the value its
      // neighbour had before this edge; blocking here would collapse the chain.
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 may be metastable, so only s2 and s3 are used downstream.
  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures the high time and rise-to-rise period of each frame
// in CLK cycles, publishes them with a one-cycle valid strobe, and declares
// a stuck line when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  // Legal range 2 .. 2**CNT_W-1, so cnt_per can never wrap before timing out.
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             level;
  logic             rise;
  logic             fall;
  logic             timeout_hit;
  cap_state_t       state;
  logic [CNT_W-1:0] cnt_per;
  logic [CNT_W-1:0] cnt_hi;

  pwm_sync_edge u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // A rise in the same cycle as the timeout wins, so the frame is still reported.
  assign timeout_hit = (cnt_per == TIMEOUT_C) && !rise;

  // Frame-measurement FSM with registered measurement outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt_per     <= '0;
      cnt_hi      <= '0;
      high_out    <= '0;
      period_out  <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      // valid is a strobe: it drops every cycle unless re-armed below.
      valid <= 1'b0;

      if (rise) begin
        // Only a rise that closes a full high+low frame is published; the rise
        // out of IDLE just opens the first frame.
        if (state == LOW) begin
          high_out   <= cnt_hi;
          period_out <= cnt_per;
          stuck      <= 1'b0;
          valid      <= 1'b1;
        end
        cnt_per <= ONE;
        cnt_hi  <= ONE;
        state   <= HIGH;
      end else if (timeout_hit) begin
        // Announce a stuck line once; while already stuck, a further timeout
        // just restarts the wait silently.
        if (!stuck) begin
          stuck       <= 1'b1;
          stuck_level <= level;
          high_out    <= '0;
          period_out  <= '0;
          valid       <= 1'b1;
        end
        cnt_per <= '0;
        state   <= IDLE;
      end else begin
        cnt_per <= cnt_per + ONE;
        if (state == HIGH) begin
          if (fall) begin
            state <= LOW;
          end else begin
            cnt_hi <= cnt_hi + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. Two instances share the stimulus:
// dut_a with TIMEOUT=255 and dut_b with TIMEOUT=20. A frame-level reference
// model (rise times and high-sample counts) predicts every output each cycle.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W = PWM_CNT_W;
  localparam int TO_A  = 255;
  localparam int TO_B  = 20;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_a, per_a, high_b, per_b;
  logic             valid_a, stuck_a, lvl_a;
  logic             valid_b, stuck_b, lvl_b;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO_A)) dut_a (
    .CLK (CLK), .RST (RST), .pwm_in (pwm_in),
    .high_out (high_a), .period_out (per_a), .valid (valid_a),
    .stuck (stuck_a), .stuck_level (lvl_a)
  );

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO_B)) dut_b (
    .CLK (CLK), .RST (RST), .pwm_in (pwm_in),
    .high_out (high_b), .period_out (per_b), .valid (valid_b),
    .stuck (stuck_b), .stuck_level (lvl_b)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // The DUT sees pwm_in two edges late (synchronizer). At processed edge n,
  // the synchronized level is the input sampled at edge n-2.
  int  edge_n;
  bit  q1, q2, q3;
  int  timeout_v [2] = '{TO_A, TO_B};
  int  origin    [2];  // edge at which the period count was 0 (rise edge counts as 1)
  int  hi_acc    [2];  // synchronized-high samples since the last rise
  bit  in_frame  [2];  // a rise has opened a frame
  bit  e_valid   [2];
  bit  e_stuck   [2];
  bit  e_lvl     [2];
  int  e_high    [2];
  int  e_per     [2];

  task automatic model_reset();
    q1 = 0; q2 = 0; q3 = 0;
    for (int i = 0; i < 2; i++) begin
      origin[i]   = edge_n + 1;
      hi_acc[i]   = 0;
      in_frame[i] = 0;
      e_valid[i]  = 0;
      e_stuck[i]  = 0;
      e_lvl[i]    = 0;
      e_high[i]   = 0;
      e_per[i]    = 0;
    end
  endtask

  task automatic model_edge(input bit p);
    bit d, r;
    edge_n++;
    d = q2;
    r = q2 && !q3;
    for (int i = 0; i < 2; i++) begin
      e_valid[i] = 0;
      if (r) begin
        if (in_frame[i]) begin
          e_high[i]  = hi_acc[i];
          e_per[i]   = edge_n - origin[i];
          e_stuck[i] = 0;
          e_valid[i] = 1;
        end
        in_frame[i] = 1;
        origin[i]   = edge_n;
        hi_acc[i]   = 1;
      end else if (edge_n - origin[i] == timeout_v[i]) begin
        if (!e_stuck[i]) begin
          e_stuck[i] = 1;
          e_lvl[i]   = d;
          e_high[i]  = 0;
          e_per[i]   = 0;
          e_valid[i] = 1;
        end
        in_frame[i] = 0;
        origin[i]   = edge_n + 1;
      end else if (in_frame[i]) begin
        hi_acc[i] += int'(d);
      end
    end
    q3 = q2; q2 = q1; q1 = p;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic v, input logic s, input logic l,
                                       input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] p);
    return {{(32 - 3 - 2*CNT_W){1'b0}}, v, s, l, h, p};
  endfunction

  // Table expectations for the frame currently being reported.
  bit               tab_chk = 0;
  logic [CNT_W-1:0] tab_hi = '0, tab_per = '0;
  logic             pv_a = 0, pv_b = 0;
  int               n_va = 0, n_sa = 0, n_vb = 0;
  int               first_vb = -1;
  int               tick_n = 0;

  // Drive one input sample, let one edge pass, compare everything #1 later.
  task automatic tick(input bit p);
    pwm_in = p;
    @(posedge CLK);
    model_edge(p);
    #1;
    tick_n++;
    check("dut_a", pack(valid_a, stuck_a, lvl_a, high_a, per_a),
          pack(e_valid[0], e_stuck[0], e_lvl[0], CNT_W'(e_high[0]), CNT_W'(e_per[0])));
    check("dut_b", pack(valid_b, stuck_b, lvl_b, high_b, per_b),
          pack(e_valid[1], e_stuck[1], e_lvl[1], CNT_W'(e_high[1]), CNT_W'(e_per[1])));
    check("valid_double", {30'b0, valid_a & pv_a, valid_b & pv_b}, 32'd0);
    if (tab_chk && valid_a && !stuck_a)
      check("table_a", {16'b0, high_a, per_a}, {16'b0, tab_hi, tab_per});
    if (valid_a) n_va++;
    if (valid_a && stuck_a) n_sa++;
    if (valid_b) begin
      n_vb++;
      if (first_vb < 0) first_vb = tick_n;
    end
    pv_a = valid_a;
    pv_b = valid_b;
  endtask

  task automatic frame(input int hi, input int per);
    for (int k = 0; k < per; k++) tick(k < hi);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_a", pack(valid_a, stuck_a, lvl_a, high_a, per_a), 32'd0);
    check("rst_async_b", pack(valid_b, stuck_b, lvl_b, high_b, per_b), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    pv_a = 0; pv_b = 0;
    tick_n = 0;
  endtask

  typedef struct {
    int hi;
    int per;
    int frames;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cur_hi, cur_per;
    vecs[0] = '{hi: 12, per: 16, frames: 4, exp_hi: 12, exp_per: 16};  // steady frames
    vecs[1] = '{hi: 4,  per: 16, frames: 3, exp_hi: 4,  exp_per: 16};  // duty 12 -> 4
    vecs[2] = '{hi: 1,  per: 5,  frames: 4, exp_hi: 1,  exp_per: 5};   // minimum pulse
    vecs[3] = '{hi: 8,  per: 16, frames: 3, exp_hi: 8,  exp_per: 16};
    edge_n = 0;

    do_reset();

    // Table-driven frames. The valid at the start of frame j reports frame j-1.
    cur_hi = 0; cur_per = 0;
    tab_chk = 1;
    n_va = 0;
    for (int v = 0; v < 4; v++) begin
      for (int f = 0; f < vecs[v].frames; f++) begin
        tab_hi  = CNT_W'(cur_hi);
        tab_per = CNT_W'(cur_per);
        cur_hi  = vecs[v].exp_hi;
        cur_per = vecs[v].exp_per;
        frame(vecs[v].hi, vecs[v].per);
      end
    end
    tab_chk = 0;
    // 14 frames, the first rise after reset is not reported.
    check("table_valid_count", n_va, 13);

    // Stuck high: the rise that starts the hold reports the last 8/16 frame,
    // then exactly one stuck strobe follows.
    n_va = 0; n_sa = 0;
    for (int k = 0; k < 300; k++) tick(1'b1);
    check("stuck_hi_valids", n_va, 2);
    check("stuck_hi_strobes", n_sa, 1);
    check("stuck_hi_out", pack(1'b0, stuck_a, lvl_a, high_a, per_a),
          pack(1'b0, 1'b1, 1'b1, '0, '0));

    // Resume: rise from IDLE opens a frame, the next rise reports and clears stuck.
    for (int f = 0; f < 3; f++) frame(12, 16);
    check("resume_out", pack(1'b0, stuck_a, 1'b0, high_a, per_a),
          pack(1'b0, 1'b0, 1'b0, CNT_W'(12), CNT_W'(16)));

    // Period exactly TIMEOUT for dut_b: rise wins over the timeout.
    for (int f = 0; f < 3; f++) frame(5, TO_B);
    check("rise_wins_b", pack(1'b0, stuck_b, 1'b0, high_b, per_b),
          pack(1'b0, 1'b0, 1'b0, CNT_W'(5), CNT_W'(TO_B)));

    // Random frames, including periods beyond dut_b's timeout.
    for (int f = 0; f < 40; f++) begin
      int per, hi;
      per = int'($urandom_range(40, 2));
      hi  = int'($urandom_range(per - 1, 1));
      frame(hi, per);
    end

    // Reset in the middle of a high phase discards the partial frame.
    frame(12, 16);
    frame(12, 16);
    for (int k = 0; k < 5; k++) tick(1'b1);
    do_reset();
    n_va = 0;
    for (int f = 0; f < 3; f++) frame(12, 16);
    check("post_rst_valids", n_va, 2);
    check("post_rst_out", {16'b0, high_a, per_a}, {16'b0, CNT_W'(12), CNT_W'(16)});

    // Stuck low from reset: cnt_per is 0 on the first edge and reaches 20 on
    // the 21st, so dut_b strobes after edge 21 and never again.
    pwm_in = 1'b0;
    do_reset();
    n_va = 0; n_vb = 0; first_vb = -1;
    for (int k = 0; k < 80; k++) tick(1'b0);
    check("stuck_lo_b_count", n_vb, 1);
    check("stuck_lo_b_edge", first_vb, 21);
    check("stuck_lo_a_count", n_va, 0);
    check("stuck_lo_b_out", pack(1'b0, stuck_b, lvl_b, high_b, per_b),
          pack(1'b0, 1'b1, 1'b0, '0, '0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
